sipo8_loader: RTL and testbench

SIPO8_LOADER -- requirements
Module: sipo8_loader

---
 rtl/sipo8_loader_pkg.sv | 13 +
 rtl/sipo8_loader_lib.sv | 49 ++++
 rtl/sipo8_loader.sv | 98 +++++++++
 tb/tb_sipo8_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo8_loader_pkg.sv
// Shared definitions for the serial-in/parallel-out byte loader: FSM encodings
// and the counter value that marks the eighth serial bit.
package sipo8_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    LOAD  = 2'b10
  } state_t;

  localparam logic [2:0] CNT_LAST = 3'd7;

endpackage

// File: rtl/sipo8_loader_lib.sv
// Small shared-library primitives used by the loader: 3-bit counter,
// 8-bit D flip-flop and 8-bit 2:1 mux.
module cnt3 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [2:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 3'd0;
    end else if (clr) begin
      q <= 3'd0;
    end else if (en) begin
      q <= q + 3'd1;
    end
  end

endmodule

module dff8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d,
  output logic [7:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 8'h00;
    end else begin
      q <= d;
    end
  end

endmodule

module mux2x8 (
  input  logic       sel,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/sipo8_loader.sv
// Collects eight serial bits into a byte and presents it with a one-cycle
// load strobe for a downstream enabled register.
module sipo8_loader
  import sipo8_loader_pkg::*;
#(
  parameter logic LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic       abort,
  input  logic       sin,
  output logic [7:0] data_out,
  output logic       load_en,
  output logic       busy,
  output logic [1:0] dbg_state
);

  state_t     state;
  logic [2:0] cnt;
  logic [7:0] sr;
  logic [7:0] sr_d;
  logic [7:0] shr;
  logic [7:0] shl;
  logic [7:0] shifted;
  logic [7:0] data_d;
  logic       shifting;
  logic       take;
  logic       cnt_clr;

  assign shr       = {sin, sr[7:1]};
  assign shl       = {sr[6:0], sin};
  assign shifting  = (state == SHIFT);
  // abort on the eighth bit wins: the byte is dropped and data_out holds
  assign take      = shifting && !abort && (cnt == CNT_LAST);
  assign cnt_clr   = (state != SHIFT) && start && !abort;
  assign dbg_state = state;

  mux2x8 u_dir_mux  (.sel(LSB_FIRST), .a(shl),      .b(shr),     .y(shifted));
  mux2x8 u_sr_mux   (.sel(shifting),  .a(sr),       .b(shifted), .y(sr_d));
  mux2x8 u_data_mux (.sel(take),      .a(data_out), .b(shifted), .y(data_d));

  dff8 u_sr   (.clk(clk), .rst(res), .d(sr_d),   .q(sr));
  dff8 u_data (.clk(clk), .rst(res), .d(data_d), .q(data_out));

  cnt3 u_cnt (.clk(clk), .rst(res), .clr(cnt_clr), .en(shifting), .q(cnt));

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state   <= IDLE;
      load_en <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          load_en <= 1'b0;
          if (start && !abort) begin
            state <= SHIFT;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        SHIFT: begin
          if (abort) begin
            state   <= IDLE;
            load_en <= 1'b0;
            busy    <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state   <= LOAD;
            load_en <= 1'b1;
            busy    <= 1'b1;
          end else begin
            load_en <= 1'b0;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          // strobe always ends here; a fresh start chains the next frame
          load_en <= 1'b0;
          if (start && !abort) begin
            state <= SHIFT;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          load_en <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo8_loader.sv
// Directed bench for sipo8_loader: both bit orders, back-to-back frames,
// abort, asynchronous reset and start/abort collision.
module tb_sipo8_loader;

  logic       clk;
  logic       res;
  logic       start;
  logic       abort;
  logic       sin;
  logic [7:0] data_out;
  logic       load_en;
  logic       busy;
  logic [1:0] dbg_state;
  logic [7:0] data_out_m;
  logic       load_en_m;
  logic       busy_m;
  logic [1:0] dbg_state_m;

  int checks;
  int failures;
  int cyc;

  // Valid/ready does not apply: start is a level request sampled on each
  // rising edge and load_en is a single-cycle strobe with no back-pressure.
  sipo8_loader #(.LSB_FIRST(1'b1)) dut (
    .clk(clk), .res(res), .start(start), .abort(abort), .sin(sin),
    .data_out(data_out), .load_en(load_en), .busy(busy), .dbg_state(dbg_state)
  );

  sipo8_loader #(.LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .res(res), .start(start), .abort(abort), .sin(sin),
    .data_out(data_out_m), .load_en(load_en_m), .busy(busy_m), .dbg_state(dbg_state_m)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // driver: start pulse accepted at the next edge
  task automatic drive_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // driver: n serial bits, bit 0 of pat first
  task automatic drive_bits(input logic [7:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      sin = pat[i];
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (data_out !== 8'h00 || load_en !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'b00) begin
      failures++;
      $display("FAIL reset_async: data=%h load=%b busy=%b st=%b required 00/0/0/00", data_out, load_en, busy, dbg_state);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (data_out_m !== 8'h00 || load_en_m !== 1'b0 || busy_m !== 1'b0 || dbg_state_m !== 2'b00) begin
      failures++;
      $display("FAIL reset_held_m: data=%h load=%b busy=%b st=%b required 00/0/0/00", data_out_m, load_en_m, busy_m, dbg_state_m);
    end
    res = 1'b0;
  endtask

  task automatic test_bit_order();
    logic [7:0] pat;
    pat = 8'hB4;
    drive_start();
    checks++;
    if (busy !== 1'b1 || dbg_state !== 2'b01) begin
      failures++;
      $display("FAIL order_enter_shift: busy=%b st=%b required 1/01", busy, dbg_state);
    end
    for (int i = 0; i < 8; i++) begin
      sin = pat[i];
      @(posedge clk); #1;
      if (i < 7) begin
        checks++;
        if (load_en !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL order_early_load bit%0d: load=%b busy=%b required 0/1", i, load_en, busy);
        end
      end
    end
    checks++;
    if (load_en !== 1'b1 || busy !== 1'b1 || data_out !== 8'hB4) begin
      failures++;
      $display("FAIL lsb_first_byte: load=%b busy=%b data=%h required 1/1/b4", load_en, busy, data_out);
    end
    checks++;
    if (load_en_m !== 1'b1 || data_out_m !== 8'h2D) begin
      failures++;
      $display("FAIL msb_first_byte: load=%b data=%h required 1/2d", load_en_m, data_out_m);
    end
    @(posedge clk); #1;
    checks++;
    if (load_en !== 1'b0 || busy !== 1'b0 || data_out !== 8'hB4 || dbg_state !== 2'b00) begin
      failures++;
      $display("FAIL order_after_load: load=%b busy=%b data=%h st=%b required 0/0/b4/00", load_en, busy, data_out, dbg_state);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat;
    int c1;
    int c2;
    c1 = 0;
    c2 = 0;
    pat = 8'hB4;
    drive_start();
    drive_bits(pat, 8);
    c1 = cyc;
    checks++;
    if (load_en !== 1'b1 || data_out !== 8'hB4) begin
      failures++;
      $display("FAIL b2b_first: load=%b data=%h required 1/b4", load_en, data_out);
    end
    drive_start();
    pat = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (load_en !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL b2b_gap bit%0d: load=%b busy=%b required 0/1", i, load_en, busy);
      end
      sin = pat[i];
      @(posedge clk); #1;
    end
    c2 = cyc;
    checks++;
    if (load_en !== 1'b1 || data_out !== 8'h5A || data_out_m !== 8'h5A) begin
      failures++;
      $display("FAIL b2b_second: load=%b data=%h data_m=%h required 1/5a/5a", load_en, data_out, data_out_m);
    end
    checks++;
    if (c2 - c1 !== 9) begin
      failures++;
      $display("FAIL b2b_period: got %0d cycles required 9", c2 - c1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    logic [7:0] pat;
    pat = 8'hB4;
    drive_start();
    drive_bits(pat, 8);
    @(posedge clk); #1;
    drive_start();
    pat = 8'hFF;
    drive_bits(pat, 4);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || load_en !== 1'b0 || dbg_state !== 2'b00 || data_out !== 8'hB4) begin
      failures++;
      $display("FAIL abort_shift: busy=%b load=%b st=%b data=%h required 0/0/00/b4", busy, load_en, dbg_state, data_out);
    end
    for (int i = 0; i < 10; i++) begin
      sin = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (load_en !== 1'b0 || data_out !== 8'hB4) begin
        failures++;
        $display("FAIL abort_quiet cyc%0d: load=%b data=%h required 0/b4", i, load_en, data_out);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] pat;
    pat = 8'h5A;
    drive_start();
    drive_bits(pat, 5);
    #2;
    res = 1'b1;
    #1;
    checks++;
    if (data_out !== 8'h00 || load_en !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'b00) begin
      failures++;
      $display("FAIL async_reset: data=%h load=%b busy=%b st=%b required 00/0/0/00", data_out, load_en, busy, dbg_state);
    end
    @(posedge clk); #1;
    res = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sin = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (load_en !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_quiet cyc%0d: load=%b busy=%b required 0/0", i, load_en, busy);
      end
    end
    res = 1'b1;
    @(posedge clk); #1;
    res = 1'b0;
    drive_start();
    checks++;
    if (busy !== 1'b1 || dbg_state !== 2'b01) begin
      failures++;
      $display("FAIL start_after_reset: busy=%b st=%b required 1/01", busy, dbg_state);
    end
    drive_bits(pat, 8);
    checks++;
    if (load_en !== 1'b1 || data_out !== 8'h5A) begin
      failures++;
      $display("FAIL frame_after_reset: load=%b data=%h required 1/5a", load_en, data_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1;
    abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sin = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || dbg_state !== 2'b00 || load_en !== 1'b0) begin
        failures++;
        $display("FAIL start_abort_idle cyc%0d: busy=%b st=%b load=%b required 0/00/0", i, busy, dbg_state, load_en);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (data_out !== 8'h5A) begin
      failures++;
      $display("FAIL start_abort_hold: data=%h required 5a", data_out);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    res      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    sin      = 1'b0;
    test_reset();
    test_bit_order();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_start_abort_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
